// File: rtl/alu_sine_phase_ctrl_if.sv
// Handshake bundle between the sine phase sequencer and the Taylor-series ALU.
// The sequencer drives the start strobe, function code and angle; the ALU
// answers with a done strobe and the signed Q2.16 result.
interface alu_sine_phase_ctrl_if;
  logic        do_calc;
  logic [2:0]  func_sel;
  logic [17:0] x_in;
  logic        calc_done;
  logic [17:0] result;

  modport master (
    output do_calc,
    output func_sel,
    output x_in,
    input  calc_done,
    input  result
  );

  modport slave (
    input  do_calc,
    input  func_sel,
    input  x_in,
    output calc_done,
    output result
  );
endinterface

// File: rtl/alu_sine_phase_ctrl.sv
// Sine sample sequencer in front of the Taylor-series ALU.
// Each accepted sample request folds the current 24-bit phase into a
// first-quadrant Q2.16 angle, starts one ALU calculation, waits for the
// result (bounded by a timeout) and applies the quadrant sign. The phase
// accumulator advances by freq_word once per accepted request.
module alu_sine_phase_ctrl (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_req,
  input  logic [23:0]                  freq_word,
  input  logic                         phase_clr,
  alu_sine_phase_ctrl_if.master        alu,
  output logic [17:0]                  sample_out,
  output logic                         sample_out_rdy,
  output logic                         overrun,
  output logic                         calc_err
);

  localparam logic [2:0]  FUNC_SEL     = 3'd1;
  localparam logic [17:0] PI_HALF      = 18'h1921F;
  localparam logic [7:0]  CALC_TIMEOUT = 8'd63;
  localparam logic [17:0] POS_MAX      = 18'h1FFFF;
  localparam logic [17:0] NEG_MIN      = 18'h20000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_REQ    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] phase_acc;
  logic        neg_reg;
  logic [7:0]  wcnt;
  logic [22:0] unfold;
  logic [17:0] x_fold;
  logic [17:0] signed_res;
  logic        timeout;

  assign timeout = (wcnt == CALC_TIMEOUT);

  // Fold the phase into [0, pi/2]: mirror odd quadrants, then scale the
  // 22-bit quadrant fraction by pi/2 (truncating).
  // NOTE: every variable written here gets a value on every path (defaults
  // or full if/else), otherwise synthesis infers a latch.
  always_comb begin
    unfold = phase_acc[22] ? (23'h400000 - {1'b0, phase_acc[21:0]})
                           : {1'b0, phase_acc[21:0]};
    x_fold = 18'(({18'd0, unfold} * {23'd0, PI_HALF}) >> 22);
  end

  // Apply the quadrant sign; negating the most negative value saturates.
  always_comb begin
    signed_res = alu.result;
    if (neg_reg) begin
      if (alu.result == NEG_MIN) signed_res = POS_MAX;
      else                       signed_res = -alu.result;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sample_req) state_nxt = S_REDUCE;
      S_REDUCE: state_nxt = S_REQ;
      S_REQ:    state_nxt = S_WAIT;
      S_WAIT:   if (alu.calc_done || timeout) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Phase accumulator: clear wins over the REDUCE increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 phase_acc <= '0;
    else if (phase_clr)           phase_acc <= '0;
    else if (state == S_REDUCE)   phase_acc <= phase_acc + freq_word;
  end

  // Angle and sign capture in REDUCE; x_in holds until the next request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu.x_in <= '0;
      neg_reg  <= 1'b0;
    end else if (state == S_REDUCE) begin
      alu.x_in <= x_fold;
      neg_reg  <= phase_acc[23];
    end
  end

  // Wait counter: cleared on entry to WAIT, counts each WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wcnt <= '0;
    else if (state == S_REQ)   wcnt <= '0;
    else if (state == S_WAIT)  wcnt <= wcnt + 8'd1;
  end

  // Registered strobes and the output sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu.do_calc    <= 1'b0;
      alu.func_sel   <= FUNC_SEL;
      sample_out     <= '0;
      sample_out_rdy <= 1'b0;
      overrun        <= 1'b0;
      calc_err       <= 1'b0;
    end else begin
      alu.do_calc    <= (state == S_REDUCE);
      alu.func_sel   <= FUNC_SEL;
      overrun        <= sample_req && (state != S_IDLE);
      sample_out_rdy <= 1'b0;
      calc_err       <= 1'b0;
      if (state == S_WAIT) begin
        if (alu.calc_done) begin
          sample_out     <= signed_res;
          sample_out_rdy <= 1'b1;
        end else if (timeout) begin
          sample_out_rdy <= 1'b1;
          calc_err       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sine_phase_ctrl.sv
// Self-checking bench for alu_sine_phase_ctrl. A stub ALU is driven from the
// request task; expected angles and samples come from a behavioural model of
// the phase/quadrant rules written with plain integer arithmetic.
module tb_alu_sine_phase_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_req;
  logic [23:0] freq_word;
  logic        phase_clr;
  logic [17:0] sample_out;
  logic        sample_out_rdy;
  logic        overrun;
  logic        calc_err;

  alu_sine_phase_ctrl_if alu_bus ();

  alu_sine_phase_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_req     (sample_req),
    .freq_word      (freq_word),
    .phase_clr      (phase_clr),
    .alu            (alu_bus),
    .sample_out     (sample_out),
    .sample_out_rdy (sample_out_rdy),
    .overrun        (overrun),
    .calc_err       (calc_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [23:0] model_phase;
  logic [17:0] last_out;

  // Angle for a phase: quadrant fraction (mirrored in odd quadrants) times pi/2.
  function automatic logic [17:0] model_x(input logic [23:0] ph);
    longint p, q, f, u;
    p = longint'(ph);
    q = p / 4194304;
    f = p % 4194304;
    u = (q % 2 == 1) ? 4194304 - f : f;
    return 18'((u * 102943) / 4194304);
  endfunction

  // Signed sample: negate in the lower half-turn, clamp to the Q2.16 range.
  function automatic logic [17:0] model_sine(input logic [23:0] ph, input logic [17:0] r);
    int v;
    v = $signed(r);
    if (ph >= 24'h800000) v = -v;
    if (v > 131071) v = 131071;
    return 18'(v);
  endfunction

  // One request starting now (cycle 0, IDLE). The stub ALU answers in cycle
  // 2+delay (delay<0: never). extra_mask bit i raises sample_req in cycle i.
  task automatic run_req(input logic [23:0] fw, input int delay, input logic [17:0] res,
                         input logic [7:0] extra_mask, input int clr_cycle,
                         output logic [17:0] x_obs, output logic [17:0] out_obs,
                         output int rdy_cnt, output int rdy_cyc, output logic err_obs,
                         output logic [15:0] ovr_mask, output int dc_cnt, output int dc_cyc);
    int cyc;
    bit done;
    cyc = 0; done = 0;
    x_obs = 'x; out_obs = 'x; err_obs = 1'bx;
    rdy_cnt = 0; rdy_cyc = -1; ovr_mask = '0; dc_cnt = 0; dc_cyc = -1;
    freq_word  = fw;
    sample_req = 1'b1;
    phase_clr  = (clr_cycle == 0);
    while (!(done && cyc >= 8) && cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (alu_bus.do_calc) begin dc_cnt++; dc_cyc = cyc; x_obs = alu_bus.x_in; end
      if (overrun && cyc < 16) ovr_mask[cyc] = 1'b1;
      if (sample_out_rdy) begin
        rdy_cnt++; rdy_cyc = cyc; out_obs = sample_out; err_obs = calc_err; done = 1;
      end
      sample_req        = (cyc < 8) ? extra_mask[cyc] : 1'b0;
      phase_clr         = (cyc == clr_cycle);
      alu_bus.calc_done = (delay >= 0) && (cyc == 2 + delay);
      alu_bus.result    = alu_bus.calc_done ? res : 18'($urandom);
    end
    sample_req = 1'b0; phase_clr = 1'b0; alu_bus.calc_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample_req = 1'b0; phase_clr = 1'b0; freq_word = '0;
    alu_bus.calc_done = 1'b0; alu_bus.result = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    model_phase = '0; last_out = '0;
    vectors++; if (alu_bus.do_calc !== 1'b0) begin miscompares++; $display("FAIL reset_do_calc: got %b want 0", alu_bus.do_calc); end
    vectors++; if (sample_out_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", sample_out_rdy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    vectors++; if (calc_err !== 1'b0) begin miscompares++; $display("FAIL reset_calc_err: got %b want 0", calc_err); end
    vectors++; if (alu_bus.x_in !== 18'h0) begin miscompares++; $display("FAIL reset_x_in: got %h want 0", alu_bus.x_in); end
    vectors++; if (sample_out !== 18'h0) begin miscompares++; $display("FAIL reset_sample_out: got %h want 0", sample_out); end
    vectors++; if (alu_bus.func_sel !== 3'd1) begin miscompares++; $display("FAIL reset_func_sel: got %0d want 1", alu_bus.func_sel); end
  endtask

  task automatic test_quadrants();
    logic [17:0] x_obs, out_obs; logic err; logic [15:0] ovr;
    int rc, rcyc, dc, dcyc;
    logic [17:0] exp_x [4];
    logic [17:0] exp_o [4];
    exp_x = '{18'h0, 18'h1921F, 18'h0, 18'h1921F};
    exp_o = '{18'h10000, 18'h10000, 18'h30000, 18'h30000};
    for (int i = 0; i < 4; i++) begin
      run_req(24'h400000, 3, 18'h10000, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
      vectors++; if (x_obs !== exp_x[i]) begin miscompares++; $display("FAIL quad_x[%0d]: got %h want %h", i, x_obs, exp_x[i]); end
      vectors++; if (out_obs !== exp_o[i]) begin miscompares++; $display("FAIL quad_out[%0d]: got %h want %h", i, out_obs, exp_o[i]); end
      vectors++; if (dc !== 1 || dcyc !== 2) begin miscompares++; $display("FAIL quad_do_calc[%0d]: got count %0d cycle %0d want 1 at 2", i, dc, dcyc); end
      vectors++; if (rc !== 1 || rcyc !== 6) begin miscompares++; $display("FAIL quad_latency[%0d]: got count %0d cycle %0d want 1 at 6", i, rc, rcyc); end
      model_phase = model_phase + 24'h400000;
      last_out = exp_o[i];
    end
  endtask

  task automatic test_half_quadrant();
    logic [17:0] x_obs, out_obs; logic err; logic [15:0] ovr;
    int rc, rcyc, dc, dcyc;
    phase_clr = 1'b1;
    @(posedge clk); #1;
    phase_clr = 1'b0;
    model_phase = '0;
    run_req(24'h200000, 2, 18'h12345, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    vectors++; if (x_obs !== 18'h0) begin miscompares++; $display("FAIL half_x0: got %h want 0", x_obs); end
    run_req(24'h200000, 2, 18'h12345, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    vectors++; if (x_obs !== 18'h0C90F) begin miscompares++; $display("FAIL half_x1: got %h want 0c90f", x_obs); end
    vectors++; if (out_obs !== 18'h12345) begin miscompares++; $display("FAIL half_sign: got %h want 12345", out_obs); end
    model_phase = 24'h400000;
    last_out = 18'h12345;
  endtask

  task automatic test_random();
    logic [17:0] x_obs, out_obs, res, ex, eo; logic err; logic [15:0] ovr;
    logic [23:0] fw;
    int rc, rcyc, dc, dcyc, dly;
    for (int i = 0; i < 12; i++) begin
      fw  = 24'($urandom);
      dly = int'($urandom_range(1, 20));
      res = ($urandom_range(0, 3) == 0) ? 18'h20000 : 18'($urandom);
      ex  = model_x(model_phase);
      eo  = model_sine(model_phase, res);
      run_req(fw, dly, res, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
      vectors++; if (x_obs !== ex) begin miscompares++; $display("FAIL rand_x[%0d]: got %h want %h", i, x_obs, ex); end
      vectors++; if (out_obs !== eo) begin miscompares++; $display("FAIL rand_out[%0d]: got %h want %h", i, out_obs, eo); end
      vectors++; if (rcyc !== dly + 3 || err !== 1'b0) begin miscompares++; $display("FAIL rand_latency[%0d]: got cycle %0d err %b want %0d err 0", i, rcyc, err, dly + 3); end
      model_phase = model_phase + fw;
      last_out = eo;
    end
  endtask

  task automatic test_overrun();
    logic [17:0] x_obs, out_obs, ex; logic err; logic [15:0] ovr;
    int rc, rcyc, dc, dcyc;
    ex = model_x(model_phase);
    run_req(24'h123457, 3, 18'h00ABC, 8'b0001_0110, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = model_phase + 24'h123457;
    last_out = model_sine(model_phase - 24'h123457, 18'h00ABC);
    vectors++; if (ovr !== 16'b0000_0000_0010_1100) begin miscompares++; $display("FAIL overrun_cycles: got %b want 0000000000101100", ovr); end
    vectors++; if (rc !== 1) begin miscompares++; $display("FAIL overrun_rdy_count: got %0d want 1", rc); end
    vectors++; if (dut.phase_acc !== model_phase) begin miscompares++; $display("FAIL overrun_phase: got %h want %h", dut.phase_acc, model_phase); end
    vectors++; if (x_obs !== ex) begin miscompares++; $display("FAIL overrun_x: got %h want %h", x_obs, ex); end
  endtask

  task automatic test_timeout();
    logic [17:0] x_obs, out_obs, ex, eo; logic err; logic [15:0] ovr;
    int rc, rcyc, dc, dcyc;
    run_req(24'h031000, -1, 18'h0, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = model_phase + 24'h031000;
    vectors++; if (rc !== 1 || rcyc !== 67) begin miscompares++; $display("FAIL timeout_cycle: got count %0d cycle %0d want 1 at 67", rc, rcyc); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b want 1", err); end
    vectors++; if (out_obs !== last_out) begin miscompares++; $display("FAIL timeout_hold: got %h want %h", out_obs, last_out); end
    ex = model_x(model_phase);
    eo = model_sine(model_phase, 18'h0F0F0);
    run_req(24'h031000, 4, 18'h0F0F0, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = model_phase + 24'h031000;
    last_out = eo;
    vectors++; if (x_obs !== ex || out_obs !== eo || rcyc !== 7 || err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_recover: got x %h out %h cycle %0d err %b want x %h out %h cycle 7 err 0", x_obs, out_obs, rcyc, err, ex, eo);
    end
  endtask

  task automatic test_phase_clr();
    logic [17:0] x_obs, out_obs, ex; logic err; logic [15:0] ovr;
    int rc, rcyc, dc, dcyc;
    run_req(24'h5A5A5A, 2, 18'h00100, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = model_phase + 24'h5A5A5A;
    ex = model_x(model_phase);
    run_req(24'h5A5A5A, 2, 18'h00100, 8'h0, 1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = '0;
    vectors++; if (x_obs !== ex) begin miscompares++; $display("FAIL clr_old_x: got %h want %h", x_obs, ex); end
    vectors++; if (dut.phase_acc !== 24'h0) begin miscompares++; $display("FAIL clr_phase: got %h want 0", dut.phase_acc); end
    vectors++; if (rc !== 1) begin miscompares++; $display("FAIL clr_completes: got %0d rdy want 1", rc); end
    run_req(24'h5A5A5A, 2, 18'h00100, 8'h0, -1, x_obs, out_obs, rc, rcyc, err, ovr, dc, dcyc);
    model_phase = 24'h5A5A5A;
    vectors++; if (x_obs !== 18'h0) begin miscompares++; $display("FAIL clr_next_x: got %h want 0", x_obs); end
  endtask

  task automatic test_reset_mid_wait();
    int rdy_seen;
    rdy_seen = 0;
    freq_word = 24'h111111;
    sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    vectors++; if ({alu_bus.do_calc, sample_out_rdy, overrun, calc_err} !== 4'b0) begin miscompares++; $display("FAIL midwait_strobes: got %b want 0000", {alu_bus.do_calc, sample_out_rdy, overrun, calc_err}); end
    vectors++; if (alu_bus.x_in !== 18'h0 || sample_out !== 18'h0) begin miscompares++; $display("FAIL midwait_data: got x %h out %h want 0 0", alu_bus.x_in, sample_out); end
    vectors++; if (dut.phase_acc !== 24'h0 || alu_bus.func_sel !== 3'd1) begin miscompares++; $display("FAIL midwait_phase: got phase %h func %0d want 0 1", dut.phase_acc, alu_bus.func_sel); end
    @(posedge clk); #1 reset_n = 1'b1;
    alu_bus.calc_done = 1'b1; alu_bus.result = 18'h0AAAA;
    @(posedge clk); #1 alu_bus.calc_done = 1'b0;
    if (sample_out_rdy) rdy_seen++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (sample_out_rdy) rdy_seen++;
    end
    vectors++; if (rdy_seen !== 0 || sample_out !== 18'h0) begin miscompares++; $display("FAIL midwait_late_done: got %0d rdy out %h want 0 rdy out 0", rdy_seen, sample_out); end
    model_phase = '0;
    last_out = '0;
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_half_quadrant();
    test_random();
    test_overrun();
    test_timeout();
    test_phase_clr();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sine_phase_ctrl.md
# alu_sine_phase_ctrl

Sequencer that sits directly upstream of the Taylor-series ALU in the oscillator path. On each sample request it advances a 24-bit phase accumulator and folds the phase into a magnitude angle in [0, π/2] (Q2.16). It issues a single-cycle `do_calc` to the ALU, waits for `calc_done`, and applies the quadrant sign to the returned value to produce one signed sine sample per request.

## Interface
- `FUNC_SEL`, 3'd1: function code driven on `func_sel` (sine).
- `PI_HALF`, 18'h1921F: π/2 in Q2.16.
- `CALC_TIMEOUT`, 8'd63: maximum cycles spent waiting for `calc_done`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_req`  in  1  one-cycle request for the next sample.
- `freq_word`  in  24  phase increment per sample (full turn = 2^24), sampled in REDUCE.
- `phase_clr`  in  1  synchronous clear of the phase accumulator.
- `do_calc`  out  1  one-cycle start strobe to the ALU.
- `func_sel`  out  3  constant `FUNC_SEL`.
- `x_in`  out  18  signed Q2.16 angle to the ALU, held between requests.
- `calc_done`  in  1  ALU result strobe.
- `result`  in  18  signed Q2.16 ALU result, valid with `calc_done`.
- `sample_out`  out  18  signed Q2.16 sine sample.
- `sample_out_rdy`  out  1  one-cycle strobe; `sample_out` is new or held.
- `overrun`  out  1  one-cycle pulse; a request was dropped.
- `calc_err`  out  1  one-cycle pulse; the ALU timed out.

## Operation
- States:
  - IDLE → REDUCE on `sample_req`.
  - REDUCE → REQ, unconditional.
  - REQ → WAIT, unconditional.
  - WAIT → IDLE on `calc_done` or on timeout.
- REDUCE:
  - q = `phase_acc`[23:22], f = `phase_acc`[21:0].
  - u = q[0] ? (2^22 − f) : f, 23-bit unsigned.
  - `x_reg` ← (u · `PI_HALF`) >> 22, truncating; range 0..0x1921F.
  - `neg_reg` ← q[1].
  - `phase_acc` ← `phase_acc` + `freq_word`, mod 2^24.
  - Sample n therefore uses phase n·`freq_word`, so the first sample after reset is at phase 0.
- REQ: `do_calc`=1 for exactly one cycle; `x_in`=`x_reg`.
- WAIT:
  - Counter `wcnt` clears on entry and increments each cycle.
  - `calc_done`=1:
    - `sample_out` ← `neg_reg` ? −`result` : `result`.
    - −(−2^17) saturates to 18'h1FFFF.
    - `sample_out_rdy`=1; go to IDLE.
  - `wcnt` == `CALC_TIMEOUT` with no done:
    - `sample_out` is held.
    - `sample_out_rdy`=1 and `calc_err`=1, so the downstream stream rate is preserved.
    - Go to IDLE.
  - `calc_done` arriving outside WAIT is ignored.
- Overrun:
  - A `sample_req` in REDUCE/REQ/WAIT is dropped; `overrun`=1 the next cycle.
  - The phase does not advance for a dropped request.
  - A `sample_req` in the same cycle the state returns to IDLE is accepted.
- `phase_clr`:
  - Sets `phase_acc` to 0 in any state.
  - Takes priority over the REDUCE increment; that cycle's x is still computed from the old phase.
  - An in-flight calculation completes normally.

## Timing
- Reset values: `do_calc`, `sample_out_rdy`, `overrun`, `calc_err` = 0; `x_in`, `sample_out` = 0; `func_sel` = `FUNC_SEL`; `phase_acc` = 0; state IDLE.
- `reset_n` low mid-WAIT aborts immediately: no `sample_out_rdy` is produced and a late `calc_done` is ignored.
- Request timing, with `sample_req` high in cycle 0 in IDLE:
  - Cycle 1: REDUCE.
  - Cycle 2: `do_calc`=1.
  - Cycle 3 onward: WAIT.
- Completion timing:
  - `calc_done` in cycle k (k≥3) gives `sample_out`/`sample_out_rdy` in cycle k+1 and IDLE in k+1.
  - Latency from request to sample is k+1.
- Timeout: `calc_err` is asserted 3+`CALC_TIMEOUT`+1 cycles after the request.
- All outputs are registered.

## Test plan
- Reset, then four `sample_req` with `freq_word`=0x400000 and a stub ALU returning 0x10000 three cycles after `do_calc`:
  - `x_in` = 0, 0x1921F, 0, 0x1921F.
  - `sample_out` = 0x10000, 0x10000, 0x30000, 0x30000.
- `freq_word`=0x200000: second request gives `x_in`=0x0C90F and `neg`=0.
- `sample_req` asserted in cycles 1, 2 and 4 after an accepted request:
  - `overrun` pulses in cycles 2, 3 and 5.
  - Exactly one `sample_out_rdy` is produced.
  - `phase_acc` advanced by only one `freq_word`.
- Stub never asserts `calc_done`:
  - `calc_err`=1 and `sample_out_rdy`=1 at cycle 67 after the request.
  - `sample_out` equals the previous value.
  - The next request proceeds normally.
- `reset_n` low for one cycle while in WAIT:
  - All outputs return to reset values.
  - A late `calc_done` produces no `sample_out_rdy`.
- `phase_clr` coincident with REDUCE: `phase_acc`=0 afterward, and the current `x_in` reflects the pre-clear phase.
